screen_scanout: RTL and testbench



---
 rtl/screen_pkg.sv | 41 ++++
 rtl/pixel_shifter.sv | 40 ++++
 rtl/screen_scanout.sv | 129 ++++++++++++
 tb/tb_screen_scanout.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// screen_pkg
// Shared constants for the Hack screen scan-out path: default raster timing,
// the derived line/frame totals, the screen word geometry and a small helper
// used to total up a timing axis.
package screen_pkg;

   // Width of one screen RAM word; each word carries 16 horizontal pixels.
   localparam int WORD_W = 16;

   // Default horizontal timing in pixel clocks.
   localparam int DEFAULT_H_ACTIVE = 512;
   localparam int DEFAULT_H_FRONT  = 16;
   localparam int DEFAULT_H_SYNC   = 32;
   localparam int DEFAULT_H_BACK   = 16;

   // Default vertical timing in lines.
   localparam int DEFAULT_V_ACTIVE = 256;
   localparam int DEFAULT_V_FRONT  = 2;
   localparam int DEFAULT_V_SYNC   = 4;
   localparam int DEFAULT_V_BACK   = 2;

   // RAM8K word address width.
   localparam int DEFAULT_ADDR_W = 13;

   // Sum of the four segments of one timing axis.
   function automatic int timing_total(input int active, input int front,
                                       input int sync, input int back);
      return active + front + sync + back;
   endfunction

   localparam int H_TOTAL = timing_total(DEFAULT_H_ACTIVE, DEFAULT_H_FRONT,
                                         DEFAULT_H_SYNC, DEFAULT_H_BACK);
   localparam int V_TOTAL = timing_total(DEFAULT_V_ACTIVE, DEFAULT_V_FRONT,
                                         DEFAULT_V_SYNC, DEFAULT_V_BACK);
   localparam int WORDS_PER_LINE = DEFAULT_H_ACTIVE / WORD_W;

   // Where the CPU sees the screen in its own address map. The scan-out side
   // addresses the RAM directly from zero, so nothing here uses this value.
   localparam int SCREEN_BASE = 16384;

endpackage

// File: rtl/pixel_shifter.sv
// pixel_shifter
// 16-bit LSB-first shift register feeding the pixel output.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset, empties the register
//   clear  - synchronous clear, used to drop a partly shifted word
//   load   - capture data; bit 0 is consumed by the caller in the same cycle,
//            so only bits 15:1 are stored
//   shift  - shift one place towards bit 0
//   data   - parallel load word
//   lsb    - next pixel to emit
module pixel_shifter
   import screen_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data,
   output logic              lsb
);

   logic [WORD_W-1:0] sr;

   // Load drops bit 0 because the top level sends that bit straight to the
   // pixel register on the fetch edge; the remaining bits follow one per clock.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         sr <= '0;
      end else if (load) begin
         sr <= data >> 1;
      end else if (shift) begin
         sr <= sr >> 1;
      end
   end

   assign lsb = sr[0];

endmodule

// File: rtl/screen_scanout.sv
// screen_scanout
// Raster scan-out for the Hack 512x256 monochrome screen. Walks the raster
// counters, reads one RAM word every 16 active pixels and emits a registered
// pixel stream with syncs and coordinates.
// Ports:
//   clock        - system clock
//   reset        - synchronous active-high reset
//   enable       - scan enable; low parks the raster at the frame origin
//   mem_address  - registered screen RAM word address
//   mem_data     - screen RAM read data, combinational from mem_address
//   pixel        - current pixel, 1 = black
//   pixel_valid  - pixel lies in the visible area
//   hsync/vsync  - active-high syncs
//   frame_start  - single-cycle pulse with pixel (0,0)
//   x, y         - coordinates of the current visible pixel, 0 in blanking
module screen_scanout
   import screen_pkg::*;
#(
   parameter int H_ACTIVE = DEFAULT_H_ACTIVE,
   parameter int H_FRONT  = DEFAULT_H_FRONT,
   parameter int H_SYNC   = DEFAULT_H_SYNC,
   parameter int H_BACK   = DEFAULT_H_BACK,
   parameter int V_ACTIVE = DEFAULT_V_ACTIVE,
   parameter int V_FRONT  = DEFAULT_V_FRONT,
   parameter int V_SYNC   = DEFAULT_V_SYNC,
   parameter int V_BACK   = DEFAULT_V_BACK,
   parameter int ADDR_W   = DEFAULT_ADDR_W
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [WORD_W-1:0] mem_data,
   output logic              pixel,
   output logic              pixel_valid,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_start,
   output logic [9:0]        x,
   output logic [8:0]        y
);

   localparam int LINE_LEN    = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int FRAME_LINES = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   localparam logic [9:0] H_LAST      = 10'(LINE_LEN - 1);
   localparam logic [9:0] H_ACT       = 10'(H_ACTIVE);
   localparam logic [9:0] H_LAST_WORD = 10'(H_ACTIVE - WORD_W);
   localparam logic [9:0] HS_START    = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS_END      = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [8:0] V_LAST      = 9'(FRAME_LINES - 1);
   localparam logic [8:0] V_ACT       = 9'(V_ACTIVE);
   localparam logic [8:0] V_LAST_ACT  = 9'(V_ACTIVE - 1);
   localparam logic [8:0] VS_START    = 9'(V_ACTIVE + V_FRONT);
   localparam logic [8:0] VS_END      = 9'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [9:0] h;
   logic [8:0] v;
   logic       active;
   logic       fetch;
   logic       sr_lsb;

   assign active = (h < H_ACT) && (v < V_ACT);
   // A word boundary in the visible area is the only place the RAM is read.
   assign fetch  = enable && active && (h[3:0] == 4'd0);

   // Dropping enable also clears the shifter so a half-used word never
   // leaks into the first word after re-enable.
   pixel_shifter u_shifter (
      .clock (clock),
      .reset (reset),
      .clear (!enable),
      .load  (fetch),
      .shift (enable && active),
      .data  (mem_data),
      .lsb   (sr_lsb)
   );

   // Raster counters and RAM address. The address simply steps once per
   // fetch, which keeps it equal to v*words_per_line + h/16 at every fetch;
   // after the final word of the frame it is parked at 0 for vertical blanking.
   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         h           <= '0;
         v           <= '0;
         mem_address <= '0;
      end else begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 9'd0 : v + 9'd1;
         end else begin
            h <= h + 10'd1;
         end
         if (fetch) begin
            if ((v == V_LAST_ACT) && (h == H_LAST_WORD)) begin
               mem_address <= '0;
            end else begin
               mem_address <= mem_address + ADDR_ONE;
            end
         end
      end
   end

   // Registered outputs, all describing the counter state of the cycle
   // before. On a fetch edge the pixel comes straight from the RAM word since
   // the shifter has not been loaded yet.
   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         pixel       <= 1'b0;
         pixel_valid <= 1'b0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         frame_start <= 1'b0;
         x           <= '0;
         y           <= '0;
      end else begin
         pixel       <= active ? (fetch ? mem_data[0] : sr_lsb) : 1'b0;
         pixel_valid <= active;
         hsync       <= (h >= HS_START) && (h < HS_END);
         vsync       <= (v >= VS_START) && (v < VS_END);
         frame_start <= (h == 10'd0) && (v == 9'd0);
         x           <= active ? h : '0;
         y           <= active ? v : '0;
      end
   end

endmodule

// File: tb/tb_screen_scanout.sv
// tb_screen_scanout
// Directed bench for screen_scanout using a shrunken raster so whole frames
// fit in a short run. Each cycle the expected registered outputs are pushed
// to a queue from a reference computed straight from the RAM contents, and
// popped after the clock edge to compare with the design.
module tb_screen_scanout;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int WPL = HA / 16;

   typedef struct packed {
      logic       pixel;
      logic       pixel_valid;
      logic       hsync;
      logic       vsync;
      logic       frame_start;
      logic [9:0] x;
      logic [8:0] y;
   } out_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [12:0] mem_address;
   logic [15:0] mem_data;
   logic        pixel, pixel_valid, hsync, vsync, frame_start;
   logic [9:0]  x;
   logic [8:0]  y;

   logic [15:0] ram [0:8191];
   out_t        exp_q [$];

   int compared   = 0;
   int mismatched = 0;
   int hm = 0, vm = 0;
   int cnt_pv, cnt_hs, cnt_vs, cnt_fs, vs_run, vs_run_max, first_hs_h, first_vs_v;
   bit pix_eq_check = 1'b0;

   always #5 clock = ~clock;

   assign mem_data = ram[mem_address];

   screen_scanout #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .ADDR_W(13)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .pixel       (pixel),
      .pixel_valid (pixel_valid),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start),
      .x           (x),
      .y           (y)
   );

   // One comparison, counted, with the failure reported through $error.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference outputs for one cycle given the inputs and raster position.
   function automatic out_t predict(input bit rst, input bit en, input int h, input int v);
      out_t        o;
      logic [15:0] w;
      bit          act;
      o = '0;
      if (!rst && en) begin
         act = (h < HA) && (v < VA);
         o.pixel_valid = act;
         if (act) begin
            w       = ram[v * WPL + h / 16];
            o.pixel = w[h % 16];
            o.x     = 10'(h);
            o.y     = 9'(v);
         end
         o.hsync       = (h >= HA + HF) && (h < HA + HF + HS);
         o.vsync       = (v >= VA + VF) && (v < VA + VF + VS);
         o.frame_start = (h == 0) && (v == 0);
      end
      return o;
   endfunction

   task automatic clearStats();
      cnt_pv = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
      vs_run = 0; vs_run_max = 0; first_hs_h = -1; first_vs_v = -1;
   endtask

   // Drive one cycle, push its expectation, then pop and compare after the edge.
   task automatic applyStimulus(input bit rst, input bit en);
      out_t ex;
      int   src_h, src_v;
      reset  = rst;
      enable = en;
      src_h  = hm;
      src_v  = vm;
      exp_q.push_back(predict(rst, en, hm, vm));
      @(posedge clock);
      #1;
      ex = exp_q.pop_front();
      checkOutput("pixel",       32'(pixel),       32'(ex.pixel));
      checkOutput("pixel_valid", 32'(pixel_valid), 32'(ex.pixel_valid));
      checkOutput("hsync",       32'(hsync),       32'(ex.hsync));
      checkOutput("vsync",       32'(vsync),       32'(ex.vsync));
      checkOutput("frame_start", 32'(frame_start), 32'(ex.frame_start));
      checkOutput("x",           32'(x),           32'(ex.x));
      checkOutput("y",           32'(y),           32'(ex.y));
      if (pix_eq_check) checkOutput("pixel_eq_valid", 32'(pixel), 32'(pixel_valid));
      cnt_pv += int'(pixel_valid);
      cnt_hs += int'(hsync);
      cnt_vs += int'(vsync);
      cnt_fs += int'(frame_start);
      if (vsync) begin
         vs_run++;
         if (vs_run > vs_run_max) vs_run_max = vs_run;
         if (first_vs_v < 0) first_vs_v = src_v;
      end else begin
         vs_run = 0;
      end
      if (hsync && first_hs_h < 0) first_hs_h = src_h;
      if (rst || !en) begin
         hm = 0;
         vm = 0;
      end else if (hm == HT - 1) begin
         hm = 0;
         vm = (vm == VT - 1) ? 0 : vm + 1;
      end else begin
         hm++;
      end
      if (hm < HA && vm < VA && hm % 16 == 0)
         checkOutput("mem_address", 32'(mem_address), 32'(vm * WPL + hm / 16));
      else if (vm >= VA)
         checkOutput("addr_vblank", 32'(mem_address), 32'd0);
   endtask

   initial begin
      foreach (ram[i]) ram[i] = 16'($urandom);
      ram[0] = 16'h0001;
      ram[1] = 16'h8000;
      reset  = 1'b1;
      enable = 1'b1;

      // Reset wins over enable for three cycles.
      repeat (3) applyStimulus(1'b1, 1'b1);
      checkOutput("reset_pixel_valid", 32'(pixel_valid), 32'd0);
      checkOutput("addr_first", 32'(mem_address), 32'd0);

      // First enabled frame: origin pulse, then the two directed words.
      clearStats();
      applyStimulus(1'b0, 1'b1);
      checkOutput("frame_start_first", 32'(frame_start), 32'd1);
      checkOutput("x_first", 32'(x), 32'd0);
      checkOutput("y_first", 32'(y), 32'd0);
      checkOutput("pix_x0", 32'(pixel), 32'd1);
      for (int c = 1; c < 32; c++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput("pix_word01", 32'(pixel), (c == 31) ? 32'd1 : 32'd0);
      end
      repeat (FRAME - 32) applyStimulus(1'b0, 1'b1);
      checkOutput("frame_pv_count", 32'(cnt_pv), 32'(HA * VA));
      checkOutput("frame_hs_count", 32'(cnt_hs), 32'(HS * VT));
      checkOutput("frame_vs_count", 32'(cnt_vs), 32'(VS * HT));
      checkOutput("vs_consecutive", 32'(vs_run_max), 32'(VS * HT));
      checkOutput("hs_start_h", 32'(first_hs_h), 32'(HA + HF));
      checkOutput("vs_start_v", 32'(first_vs_v), 32'(VA + VF));
      checkOutput("frame_fs_count", 32'(cnt_fs), 32'd1);

      // Reset in the middle of a line restarts at the origin.
      for (int i = 0; i < 2 * FRAME && !(hm == 30 && vm == 1); i++) applyStimulus(1'b0, 1'b1);
      checkOutput("reach_reset_point", 32'(hm == 30 && vm == 1), 32'd1);
      repeat (2) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("fs_after_reset", 32'(frame_start), 32'd1);

      // Enable dropped mid-word for five cycles.
      for (int i = 0; i < 2 * FRAME && !(hm == 20 && vm == 2); i++) applyStimulus(1'b0, 1'b1);
      checkOutput("reach_drop_point", 32'(hm == 20 && vm == 2), 32'd1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("drop_pixel_valid", 32'(pixel_valid), 32'd0);
      checkOutput("drop_mem_address", 32'(mem_address), 32'd0);
      repeat (4) applyStimulus(1'b0, 1'b0);
      foreach (ram[i]) ram[i] = 16'hFFFF;

      // Re-enable into two all-black frames.
      clearStats();
      pix_eq_check = 1'b1;
      applyStimulus(1'b0, 1'b1);
      checkOutput("fs_reenable", 32'(frame_start), 32'd1);
      checkOutput("x_reenable", 32'(x), 32'd0);
      checkOutput("y_reenable", 32'(y), 32'd0);
      repeat (2 * FRAME - 1) applyStimulus(1'b0, 1'b1);
      checkOutput("two_frame_fs_count", 32'(cnt_fs), 32'd2);
      checkOutput("two_frame_pv_count", 32'(cnt_pv), 32'(2 * HA * VA));
      pix_eq_check = 1'b0;

      applyStimulus(1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
